// File: rtl/rename_nwide.sv
// rename_nwide: WIDTH-wide register rename stage.
// Renames an in-order prefix of up to WIDTH decoded slots per cycle against the
// F-RAT, allocates destinations from the free-list head, and resolves
// intra-group RAW/WAW hazards. The renamed group is registered behind a
// valid/ready handshake. Groups are accepted whole or not at all.
// Optional feature: define RENAME_STALL_CNT_EN to add saturating per-cause stall counters.
module rename_nwide #(
  parameter int WIDTH     = 2,
  parameter int LOG_ARCH  = 5,
  parameter int NUM_ARCH  = 32,
  parameter int LOG_PHYS  = 6,
  parameter int PAYLOAD_W = 128,
  parameter int CRED_W    = 6,
  localparam int POP_W    = $clog2(WIDTH + 1)
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          Flush,
  input  logic [WIDTH-1:0]              In_valid,
  input  logic [WIDTH*LOG_ARCH-1:0]     In_src_a,
  input  logic [WIDTH*LOG_ARCH-1:0]     In_src_b,
  input  logic [WIDTH*LOG_ARCH-1:0]     In_dst,
  input  logic [WIDTH-1:0]              In_regwrite,
  input  logic [WIDTH-1:0]              In_is_mem,
  input  logic [WIDTH*PAYLOAD_W-1:0]    In_payload,
  output logic                          In_ready,
  input  logic [NUM_ARCH*LOG_PHYS-1:0]  Map_flat,
  input  logic [NUM_ARCH-1:0]           Busy_list,
  input  logic [WIDTH*LOG_PHYS-1:0]     Free_regs,
  input  logic [LOG_PHYS:0]             Free_count,
  input  logic [CRED_W-1:0]             Rob_cred,
  input  logic [CRED_W-1:0]             Iq_cred,
  input  logic [CRED_W-1:0]             Lsq_cred,
  output logic [POP_W-1:0]              Free_pop_cnt,
  output logic [WIDTH-1:0]              Rat_wr_en,
  output logic [WIDTH*LOG_ARCH-1:0]     Rat_wr_arch,
  output logic [WIDTH*LOG_PHYS-1:0]     Rat_wr_phys,
  output logic [WIDTH-1:0]              Out_valid,
  input  logic                          Out_ready,
  output logic [WIDTH*LOG_PHYS-1:0]     Out_src_a_phys,
  output logic [WIDTH*LOG_PHYS-1:0]     Out_src_b_phys,
  output logic [WIDTH-1:0]              Out_src_a_rdy,
  output logic [WIDTH-1:0]              Out_src_b_rdy,
  output logic [WIDTH*LOG_PHYS-1:0]     Out_dst_phys,
  output logic [WIDTH*LOG_PHYS-1:0]     Out_old_phys,
  output logic [WIDTH-1:0]              Out_has_dst,
  output logic [WIDTH*PAYLOAD_W-1:0]    Out_payload,
  output logic                          Blocked,
  output logic [2:0]                    Stall_reason
`ifdef RENAME_STALL_CNT_EN
  ,
  output logic [31:0]                   Stall_cnt_rob,
  output logic [31:0]                   Stall_cnt_fl,
  output logic [31:0]                   Stall_cnt_iq,
  output logic [31:0]                   Stall_cnt_lsq,
  output logic [31:0]                   Stall_cnt_bp
`endif
);

  // Counts are widened so credit and free-count compares never truncate.
  localparam int CMP_W = (CRED_W > LOG_PHYS + 1) ? CRED_W : LOG_PHYS + 1;

  localparam logic [2:0] CAUSE_NONE = 3'd0;
  localparam logic [2:0] CAUSE_BP   = 3'd1;
  localparam logic [2:0] CAUSE_ROB  = 3'd2;
  localparam logic [2:0] CAUSE_FL   = 3'd3;
  localparam logic [2:0] CAUSE_IQ   = 3'd4;
  localparam logic [2:0] CAUSE_LSQ  = 3'd5;

  logic [LOG_ARCH-1:0] src_a    [WIDTH];
  logic [LOG_ARCH-1:0] src_b    [WIDTH];
  logic [LOG_ARCH-1:0] dst      [WIDTH];
  logic [LOG_PHYS-1:0] free_arr [WIDTH];
  logic [LOG_PHYS-1:0] map_arr  [NUM_ARCH];

  logic [WIDTH-1:0]    vld, wr, mem, last_wr, sa_rdy, sb_rdy;
  logic [LOG_PHYS-1:0] new_phys [WIDTH];
  logic [LOG_PHYS-1:0] sa_phys  [WIDTH];
  logic [LOG_PHYS-1:0] sb_phys  [WIDTH];
  logic [LOG_PHYS-1:0] old_phys [WIDTH];
  logic [CMP_W-1:0]    nv, nd, nm;

  logic out_free, rob_ok, fl_ok, iq_ok, lsq_ok, fire;
  logic [2:0] cause;

  logic [WIDTH*LOG_PHYS-1:0] nxt_sa_phys, nxt_sb_phys, nxt_dst_phys, nxt_old_phys;

  // Unpack flat buses into per-slot / per-arch-reg arrays.
  always_comb begin
    for (int a = 0; a < NUM_ARCH; a++) begin
      map_arr[a] = Map_flat[a*LOG_PHYS +: LOG_PHYS];
    end
    for (int j = 0; j < WIDTH; j++) begin
      src_a[j]    = In_src_a[j*LOG_ARCH +: LOG_ARCH];
      src_b[j]    = In_src_b[j*LOG_ARCH +: LOG_ARCH];
      dst[j]      = In_dst[j*LOG_ARCH +: LOG_ARCH];
      free_arr[j] = Free_regs[j*LOG_PHYS +: LOG_PHYS];
    end
  end

  // Slot qualification, resource counts and in-order free-list allocation.
  always_comb begin
    int   cnt;
    logic run;
    vld = '0;
    wr  = '0;
    mem = '0;
    nv  = '0;
    nd  = '0;
    nm  = '0;
    cnt = 0;
    run = 1'b1;
    for (int j = 0; j < WIDTH; j++) begin
      // Only the contiguous prefix from slot 0 is treated as valid.
      run    = run & In_valid[j];
      vld[j] = run;
      wr[j]  = vld[j] & In_regwrite[j] & (dst[j] != '0);
      mem[j] = vld[j] & In_is_mem[j];
      new_phys[j] = '0;
      for (int k = 0; k < WIDTH; k++) begin
        if (wr[j] && k == cnt) new_phys[j] = free_arr[k];
      end
      if (vld[j]) nv = nv + CMP_W'(1);
      if (mem[j]) nm = nm + CMP_W'(1);
      if (wr[j]) begin
        nd  = nd + CMP_W'(1);
        cnt = cnt + 1;
      end
    end
  end

  // Source/old-mapping lookup with in-group bypass; youngest older writer wins.
  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      sa_phys[j]  = map_arr[src_a[j]];
      sa_rdy[j]   = ~Busy_list[src_a[j]];
      sb_phys[j]  = map_arr[src_b[j]];
      sb_rdy[j]   = ~Busy_list[src_b[j]];
      old_phys[j] = map_arr[dst[j]];
      for (int i = 0; i < j; i++) begin
        if (wr[i] && dst[i] == src_a[j]) begin
          sa_phys[j] = new_phys[i];
          sa_rdy[j]  = 1'b0;
        end
        if (wr[i] && dst[i] == src_b[j]) begin
          sb_phys[j] = new_phys[i];
          sb_rdy[j]  = 1'b0;
        end
        if (wr[i] && dst[i] == dst[j]) old_phys[j] = new_phys[i];
      end
      if (src_a[j] == '0) begin
        sa_phys[j] = '0;
        sa_rdy[j]  = 1'b1;
      end
      if (src_b[j] == '0) begin
        sb_phys[j] = '0;
        sb_rdy[j]  = 1'b1;
      end
      if (!wr[j]) old_phys[j] = '0;
      // A younger writer of the same arch reg supersedes this slot's RAT update.
      last_wr[j] = wr[j];
      for (int i = j + 1; i < WIDTH; i++) begin
        if (wr[i] && dst[i] == dst[j]) last_wr[j] = 1'b0;
      end
    end
  end

  // Accept decision and stall cause (bp > ROB > FL > IQ > LSQ).
  always_comb begin
    out_free = ~Out_valid[0] | Out_ready;
    rob_ok   = CMP_W'(Rob_cred)   >= nv;
    fl_ok    = CMP_W'(Free_count) >= nd;
    iq_ok    = CMP_W'(Iq_cred)    >= nv;
    lsq_ok   = CMP_W'(Lsq_cred)   >= nm;
    In_ready = ~Flush & out_free & rob_ok & fl_ok & iq_ok & lsq_ok;
    fire     = In_valid[0] & In_ready;
    cause    = CAUSE_NONE;
    if (!Flush && In_valid[0]) begin
      if (!out_free)    cause = CAUSE_BP;
      else if (!rob_ok) cause = CAUSE_ROB;
      else if (!fl_ok)  cause = CAUSE_FL;
      else if (!iq_ok)  cause = CAUSE_IQ;
      else if (!lsq_ok) cause = CAUSE_LSQ;
    end
  end

  // Free-list pop, F-RAT write port and flattened next-group fields.
  always_comb begin
    Free_pop_cnt = fire ? nd[POP_W-1:0] : '0;
    Rat_wr_en    = fire ? last_wr : '0;
    for (int j = 0; j < WIDTH; j++) begin
      Rat_wr_arch[j*LOG_ARCH +: LOG_ARCH]  = dst[j];
      Rat_wr_phys[j*LOG_PHYS +: LOG_PHYS]  = new_phys[j];
      nxt_sa_phys[j*LOG_PHYS +: LOG_PHYS]  = sa_phys[j];
      nxt_sb_phys[j*LOG_PHYS +: LOG_PHYS]  = sb_phys[j];
      nxt_dst_phys[j*LOG_PHYS +: LOG_PHYS] = new_phys[j];
      nxt_old_phys[j*LOG_PHYS +: LOG_PHYS] = old_phys[j];
    end
  end

  // Output group register: load on Fire, drop on Flush or when consumed.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Out_valid      <= '0;
      Out_src_a_phys <= '0;
      Out_src_b_phys <= '0;
      Out_src_a_rdy  <= '0;
      Out_src_b_rdy  <= '0;
      Out_dst_phys   <= '0;
      Out_old_phys   <= '0;
      Out_has_dst    <= '0;
      Out_payload    <= '0;
      Blocked        <= 1'b0;
      Stall_reason   <= CAUSE_NONE;
    end else begin
      Blocked      <= (cause != CAUSE_NONE);
      Stall_reason <= cause;
      if (Flush) begin
        Out_valid <= '0;
      end else if (fire) begin
        Out_valid      <= vld;
        Out_src_a_phys <= nxt_sa_phys;
        Out_src_b_phys <= nxt_sb_phys;
        Out_src_a_rdy  <= sa_rdy;
        Out_src_b_rdy  <= sb_rdy;
        Out_dst_phys   <= nxt_dst_phys;
        Out_old_phys   <= nxt_old_phys;
        Out_has_dst    <= wr;
        Out_payload    <= In_payload;
      end else if (Out_ready) begin
        Out_valid <= '0;
      end
    end
  end

`ifdef RENAME_STALL_CNT_EN
  // Per-cause saturating stall counters, cleared only by reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Stall_cnt_rob <= '0;
      Stall_cnt_fl  <= '0;
      Stall_cnt_iq  <= '0;
      Stall_cnt_lsq <= '0;
      Stall_cnt_bp  <= '0;
    end else begin
      if (cause == CAUSE_ROB && Stall_cnt_rob != '1) Stall_cnt_rob <= Stall_cnt_rob + 32'd1;
      if (cause == CAUSE_FL  && Stall_cnt_fl  != '1) Stall_cnt_fl  <= Stall_cnt_fl  + 32'd1;
      if (cause == CAUSE_IQ  && Stall_cnt_iq  != '1) Stall_cnt_iq  <= Stall_cnt_iq  + 32'd1;
      if (cause == CAUSE_LSQ && Stall_cnt_lsq != '1) Stall_cnt_lsq <= Stall_cnt_lsq + 32'd1;
      if (cause == CAUSE_BP  && Stall_cnt_bp  != '1) Stall_cnt_bp  <= Stall_cnt_bp  + 32'd1;
    end
  end
`else
  // Stall counters not built in this configuration.
`endif

endmodule

// File: tb/tb_rename_nwide.sv
// Directed bench for rename_nwide at WIDTH=2: allocation, bypass, WAW,
// stall causes and priority, backpressure hold, flush and async reset.
module tb_rename_nwide;

  localparam int WIDTH = 2, LOG_ARCH = 5, NUM_ARCH = 32, LOG_PHYS = 6;
  localparam int PAYLOAD_W = 128, CRED_W = 6;

  logic                         CLK = 1'b0;
  logic                         RESET;
  logic                         Flush;
  logic [WIDTH-1:0]             In_valid;
  logic [WIDTH*LOG_ARCH-1:0]    In_src_a, In_src_b, In_dst;
  logic [WIDTH-1:0]             In_regwrite, In_is_mem;
  logic [WIDTH*PAYLOAD_W-1:0]   In_payload;
  logic                         In_ready;
  logic [NUM_ARCH*LOG_PHYS-1:0] Map_flat;
  logic [NUM_ARCH-1:0]          Busy_list;
  logic [WIDTH*LOG_PHYS-1:0]    Free_regs;
  logic [LOG_PHYS:0]            Free_count;
  logic [CRED_W-1:0]            Rob_cred, Iq_cred, Lsq_cred;
  logic [1:0]                   Free_pop_cnt;
  logic [WIDTH-1:0]             Rat_wr_en;
  logic [WIDTH*LOG_ARCH-1:0]    Rat_wr_arch;
  logic [WIDTH*LOG_PHYS-1:0]    Rat_wr_phys;
  logic [WIDTH-1:0]             Out_valid;
  logic                         Out_ready;
  logic [WIDTH*LOG_PHYS-1:0]    Out_src_a_phys, Out_src_b_phys, Out_dst_phys, Out_old_phys;
  logic [WIDTH-1:0]             Out_src_a_rdy, Out_src_b_rdy, Out_has_dst;
  logic [WIDTH*PAYLOAD_W-1:0]   Out_payload;
  logic                         Blocked;
  logic [2:0]                   Stall_reason;

  int n_vec = 0;
  int n_err = 0;

  rename_nwide #(
    .WIDTH(WIDTH), .LOG_ARCH(LOG_ARCH), .NUM_ARCH(NUM_ARCH), .LOG_PHYS(LOG_PHYS),
    .PAYLOAD_W(PAYLOAD_W), .CRED_W(CRED_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .Flush(Flush),
    .In_valid(In_valid), .In_src_a(In_src_a), .In_src_b(In_src_b), .In_dst(In_dst),
    .In_regwrite(In_regwrite), .In_is_mem(In_is_mem), .In_payload(In_payload),
    .In_ready(In_ready), .Map_flat(Map_flat), .Busy_list(Busy_list),
    .Free_regs(Free_regs), .Free_count(Free_count),
    .Rob_cred(Rob_cred), .Iq_cred(Iq_cred), .Lsq_cred(Lsq_cred),
    .Free_pop_cnt(Free_pop_cnt), .Rat_wr_en(Rat_wr_en),
    .Rat_wr_arch(Rat_wr_arch), .Rat_wr_phys(Rat_wr_phys),
    .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Out_src_a_phys(Out_src_a_phys), .Out_src_b_phys(Out_src_b_phys),
    .Out_src_a_rdy(Out_src_a_rdy), .Out_src_b_rdy(Out_src_b_rdy),
    .Out_dst_phys(Out_dst_phys), .Out_old_phys(Out_old_phys),
    .Out_has_dst(Out_has_dst), .Out_payload(Out_payload),
    .Blocked(Blocked), .Stall_reason(Stall_reason)
  );

  // 10-unit clock, posedges at 5, 15, ...
  always #5 CLK = ~CLK;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to the next negedge to drive, then sample comb outputs 1 unit later.
  task automatic to_drive();
    @(negedge CLK);
  endtask

  task automatic after_edge();
    @(posedge CLK);
    #1;
  endtask

  localparam logic [127:0] P0 = 128'hA0A0_0000_0000_0000_0000_0000_0000_00A0;
  localparam logic [127:0] P1 = 128'hB1B1_1111_2222_3333_4444_5555_6666_77B1;
  localparam logic [127:0] P2 = 128'hC2C2_DEAD_BEEF_0000_1234_5678_9ABC_DEF0;

  initial begin
    // F-RAT: arch r maps to phys r+20.
    for (int a = 0; a < NUM_ARCH; a++) Map_flat[a*LOG_PHYS +: LOG_PHYS] = 6'(a + 20);
    Busy_list   = 32'h0000_0042;   // r1 and r6 busy
    RESET       = 1'b1;
    Flush       = 1'b0;
    In_valid    = '0;
    In_src_a    = '0;
    In_src_b    = '0;
    In_dst      = '0;
    In_regwrite = '0;
    In_is_mem   = '0;
    In_payload  = '0;
    Free_regs   = '0;
    Free_count  = 7'd20;
    Rob_cred    = 6'd16;
    Iq_cred     = 6'd16;
    Lsq_cred    = 6'd16;
    Out_ready   = 1'b1;

    #12;
    chk("rst_out_valid", Out_valid, 2'b00);
    chk("rst_blocked", Blocked, 1'b0);
    chk("rst_stall_reason", Stall_reason, 3'd0);
    chk("rst_dst_phys", Out_dst_phys, 12'h0);
    to_drive();
    RESET = 1'b0;

    // Basic two-slot group: dst r3/r4, slot1 src_b r3 bypasses from slot0.
    to_drive();
    In_valid    = 2'b11;
    In_regwrite = 2'b11;
    In_dst      = {5'd4, 5'd3};
    In_src_a    = {5'd2, 5'd1};
    In_src_b    = {5'd3, 5'd0};
    Free_regs   = {6'd9, 6'd8};
    In_payload  = {P1, P0};
    #1;
    chk("a_in_ready", In_ready, 1'b1);
    chk("a_pop_cnt", Free_pop_cnt, 2'd2);
    chk("a_rat_wr_en", Rat_wr_en, 2'b11);
    chk("a_rat_wr_phys", Rat_wr_phys, {6'd9, 6'd8});
    after_edge();
    chk("a_out_valid", Out_valid, 2'b11);
    chk("a_dst_phys", Out_dst_phys, {6'd9, 6'd8});
    chk("a_src_a_phys", Out_src_a_phys, {6'd22, 6'd21});
    chk("a_src_a_rdy", Out_src_a_rdy, 2'b10);
    chk("a_src_b_phys", Out_src_b_phys, {6'd8, 6'd0});
    chk("a_src_b_rdy", Out_src_b_rdy, 2'b01);
    chk("a_old_phys", Out_old_phys, {6'd24, 6'd23});
    chk("a_has_dst", Out_has_dst, 2'b11);
    chk("a_payload0", Out_payload[127:0], P0);

    // RAW: slot0 dst r5, slot1 reads r5; replaces the held group (Out_ready=1).
    to_drive();
    In_dst     = {5'd6, 5'd5};
    In_src_a   = {5'd5, 5'd0};
    In_src_b   = {5'd6, 5'd0};
    Free_regs  = {6'd11, 6'd10};
    In_payload = {P0, P2};
    #1;
    chk("b_in_ready", In_ready, 1'b1);
    after_edge();
    chk("b_src_a_phys", Out_src_a_phys, {6'd10, 6'd0});
    chk("b_src_a_rdy", Out_src_a_rdy, 2'b01);
    chk("b_src_b_phys", Out_src_b_phys, {6'd26, 6'd0});
    chk("b_src_b_rdy", Out_src_b_rdy, 2'b01);
    chk("b_old_phys", Out_old_phys, {6'd26, 6'd25});
    chk("b_dst_phys", Out_dst_phys, {6'd11, 6'd10});
    chk("b_payload0", Out_payload[127:0], P2);

    // WAW: both slots write r7.
    to_drive();
    In_dst    = {5'd7, 5'd7};
    In_src_a  = '0;
    In_src_b  = '0;
    Free_regs = {6'd13, 6'd12};
    #1;
    chk("c_rat_wr_en", Rat_wr_en, 2'b10);
    chk("c_pop_cnt", Free_pop_cnt, 2'd2);
    after_edge();
    chk("c_old_phys", Out_old_phys, {6'd12, 6'd27});
    chk("c_dst_phys", Out_dst_phys, {6'd13, 6'd12});

    // Single slot, regwrite to r0: no allocation, no RAT write.
    to_drive();
    In_valid    = 2'b01;
    In_regwrite = 2'b01;
    In_is_mem   = 2'b01;
    In_dst      = {5'd0, 5'd0};
    #1;
    chk("d_pop_cnt", Free_pop_cnt, 2'd0);
    chk("d_rat_wr_en", Rat_wr_en, 2'b00);
    after_edge();
    chk("d_out_valid", Out_valid, 2'b01);
    chk("d_has_dst", Out_has_dst, 2'b00);
    chk("d_dst_phys", Out_dst_phys, 12'h0);

    // Free-list shortage: nd=2, Free_count=1.
    to_drive();
    In_valid    = 2'b11;
    In_regwrite = 2'b11;
    In_is_mem   = 2'b00;
    In_dst      = {5'd4, 5'd3};
    Free_count  = 7'd1;
    #1;
    chk("e_in_ready", In_ready, 1'b0);
    chk("e_pop_cnt", Free_pop_cnt, 2'd0);
    after_edge();
    chk("e_blocked", Blocked, 1'b1);
    chk("e_stall_reason", Stall_reason, 3'd3);
    chk("e_out_valid", Out_valid, 2'b00);
    to_drive();
    Free_count = 7'd2;
    #1;
    chk("e2_in_ready", In_ready, 1'b1);
    after_edge();
    chk("e2_out_valid", Out_valid, 2'b11);
    chk("e2_blocked", Blocked, 1'b0);
    chk("e2_stall_reason", Stall_reason, 3'd0);

    // Priority: ROB short and FL short -> ROB.
    to_drive();
    Rob_cred   = 6'd1;
    Free_count = 7'd0;
    after_edge();
    chk("f_rob_over_fl", Stall_reason, 3'd2);
    // FL short and IQ short -> FL.
    to_drive();
    Rob_cred = 6'd16;
    Iq_cred  = 6'd1;
    after_edge();
    chk("f_fl_over_iq", Stall_reason, 3'd3);
    // IQ only.
    to_drive();
    Free_count = 7'd20;
    after_edge();
    chk("f_iq", Stall_reason, 3'd4);
    // LSQ only: two memory slots, one credit.
    to_drive();
    Iq_cred   = 6'd16;
    In_is_mem = 2'b11;
    Lsq_cred  = 6'd1;
    #1;
    chk("f_lsq_in_ready", In_ready, 1'b0);
    after_edge();
    chk("f_lsq", Stall_reason, 3'd5);
    // Exactly enough LSQ credits -> Fire.
    to_drive();
    Lsq_cred   = 6'd2;
    Free_regs  = {6'd31, 6'd30};
    In_payload = {P0, P1};
    #1;
    chk("f_lsq_exact", In_ready, 1'b1);
    after_edge();
    chk("f_out_valid", Out_valid, 2'b11);

    // Backpressure: Out held for two cycles while new input waits.
    to_drive();
    Out_ready  = 1'b0;
    Free_regs  = {6'd40, 6'd41};
    In_payload = {P2, P2};
    #1;
    chk("g_in_ready", In_ready, 1'b0);
    for (int c = 0; c < 2; c++) begin
      after_edge();
      chk("g_hold_valid", Out_valid, 2'b11);
      chk("g_hold_dst", Out_dst_phys, {6'd31, 6'd30});
      chk("g_hold_payload", Out_payload[127:0], P1);
      chk("g_stall_bp", Stall_reason, 3'd1);
    end
    to_drive();
    Flush = 1'b1;
    #1;
    chk("g_flush_in_ready", In_ready, 1'b0);
    chk("g_flush_rat", Rat_wr_en, 2'b00);
    chk("g_flush_pop", Free_pop_cnt, 2'd0);
    after_edge();
    chk("g_flush_valid", Out_valid, 2'b00);
    chk("g_flush_stall", Stall_reason, 3'd0);
    chk("g_flush_blocked", Blocked, 1'b0);

    // Fire into empty output, then stall on backpressure and pulse reset mid-cycle.
    to_drive();
    Flush = 1'b0;
    after_edge();
    chk("h_out_valid", Out_valid, 2'b11);
    after_edge();
    chk("h_blocked", Blocked, 1'b1);
    chk("h_stall_bp", Stall_reason, 3'd1);
    #2;
    RESET = 1'b1;
    #1;
    chk("h_rst_valid", Out_valid, 2'b00);
    chk("h_rst_blocked", Blocked, 1'b0);
    chk("h_rst_stall", Stall_reason, 3'd0);
    chk("h_rst_dst", Out_dst_phys, 12'h0);
    to_drive();
    RESET = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
